// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: host export bus into the instruction memory.
interface instruction_fetch_if #(parameter int AW = 8);
  logic [AW-1:0] address;
  logic [31:0]   data;
  logic          mw;
  logic          mr;
  logic [31:0]   out;
  modport master (output address, data, mw, mr, input out);
  modport slave  (input address, data, mw, mr, output out);
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, 256x32 instruction memory, instruction register and host export port.
module instruction_fetch #(
  parameter int          MEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                ctr_PC_src,
  input  logic                ctr_nop,
  input  logic [31:0]         PCin,
  output logic [31:0]         PC,
  output logic [31:0]         Instr,
  instruction_fetch_if.slave  instmem_export
);
  localparam int AW = $clog2(MEM_DEPTH);
  logic [31:0] mem [MEM_DEPTH];
  // host writes ignore reset so the program can be loaded while the core is held
  always_ff @(posedge clk)
    if (instmem_export.mw) mem[instmem_export.address] <= instmem_export.data;
  assign instmem_export.out = instmem_export.mr ? mem[instmem_export.address] : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      PC    <= RESET_PC;
      Instr <= '0;
    end else if (enable) begin
      Instr <= ctr_nop ? '0 : mem[PC[AW+1:2]];
      PC    <= ctr_nop ? PC : ctr_PC_src ? PCin : PC + 32'd4;
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed test of fetch, jump, NOP, hold, async reset and host port.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        reset, enable, ctr_PC_src, ctr_nop;
  logic [31:0] PCin, PC, Instr;
  int          n_chk = 0, n_pass = 0;

  instruction_fetch_if #(.AW(8)) bus ();

  instruction_fetch dut (
    .clk(clk), .reset(reset), .enable(enable), .ctr_PC_src(ctr_PC_src),
    .ctr_nop(ctr_nop), .PCin(PCin), .PC(PC), .Instr(Instr), .instmem_export(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    chk(tag, bus.out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b0; ctr_PC_src = 1'b0; ctr_nop = 1'b0; PCin = '0;
    bus.address = '0; bus.data = '0; bus.mw = 1'b0; bus.mr = 1'b0;
    repeat (4) tick();
    chk("reset_pc", PC, 32'h0);
    chk("reset_instr", Instr, 32'h0);
    reset = 1'b0;
    tick();
    chk("post_reset_pc", PC, 32'h0);

    bus.mw = 1'b1; bus.mr = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.address = 8'(i);
      bus.data = (i == 1) ? 32'h8C08_0002 : (i == 2) ? 32'hAC08_0001 : (i == 8) ? 32'hFFFF_FFFF : 32'h0;
      tick();
    end
    bus.mw = 1'b0;
    rd("rb_w0", 8'd0, 32'h0);
    rd("rb_w1", 8'd1, 32'h8C08_0002);
    rd("rb_w2", 8'd2, 32'hAC08_0001);
    rd("rb_w3", 8'd3, 32'h0);
    rd("rb_w8", 8'd8, 32'hFFFF_FFFF);
    rd("rb_w255", 8'd255, 32'h0);
    bus.mr = 1'b0;
    rd("rb_mr0", 8'd1, 32'h0);
    chk("idle_pc", PC, 32'h0);

    bus.mr = 1'b1; bus.address = 8'd5; bus.data = 32'h1234_5678; bus.mw = 1'b1;
    #1 chk("rw_old", bus.out, 32'h0);
    tick();
    chk("rw_new", bus.out, 32'h1234_5678);
    bus.data = 32'h0;
    tick();
    bus.mw = 1'b0;

    enable = 1'b1;
    tick(); chk("seq_pc4", PC, 32'd4);  chk("seq_i0", Instr, 32'h0);
    tick(); chk("seq_pc8", PC, 32'd8);  chk("seq_i1", Instr, 32'h8C08_0002);
    tick(); chk("seq_pc12", PC, 32'd12); chk("seq_i2", Instr, 32'hAC08_0001);
    tick(); chk("seq_pc16", PC, 32'd16); chk("seq_i3", Instr, 32'h0);

    PCin = 32'd32; ctr_PC_src = 1'b1;
    tick(); chk("jmp_pc", PC, 32'd32);
    ctr_PC_src = 1'b0;
    tick(); chk("jmp_instr", Instr, 32'hFFFF_FFFF); chk("jmp_pc_next", PC, 32'd36);

    ctr_nop = 1'b1; ctr_PC_src = 1'b1; PCin = 32'd100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("nop_instr", Instr, 32'h0);
      chk("nop_pc", PC, 32'd36);
    end
    ctr_nop = 1'b0; ctr_PC_src = 1'b0;
    tick(); chk("resume_pc", PC, 32'd40); chk("resume_instr", Instr, 32'h0);

    PCin = 32'd4; ctr_PC_src = 1'b1;
    tick(); chk("jmp4_pc", PC, 32'd4);
    ctr_PC_src = 1'b0;
    tick(); chk("jmp4_instr", Instr, 32'h8C08_0002); chk("jmp4_pc_next", PC, 32'd8);

    enable = 1'b0; ctr_nop = 1'b1; ctr_PC_src = 1'b1;
    repeat (3) tick();
    chk("hold_pc", PC, 32'd8);
    chk("hold_instr", Instr, 32'h8C08_0002);
    enable = 1'b1; ctr_nop = 1'b0; PCin = 32'd36;
    tick(); chk("pre_rst_pc", PC, 32'd36); chk("pre_rst_instr", Instr, 32'hAC08_0001);
    ctr_PC_src = 1'b0;

    #2 reset = 1'b1;
    #1 chk("async_rst_pc", PC, 32'h0);
    chk("async_rst_instr", Instr, 32'h0);
    #1 reset = 1'b0;
    rd("rst_mem_w8", 8'd8, 32'hFFFF_FFFF);
    rd("rst_mem_w1", 8'd1, 32'h8C08_0002);

    bus.address = 8'd0; bus.data = 32'hDEAD_BEEF; bus.mw = 1'b1;
    tick(); chk("coll_instr", Instr, 32'h0); chk("coll_pc", PC, 32'd4);
    bus.mw = 1'b0;
    rd("coll_mem", 8'd0, 32'hDEAD_BEEF);

    bus.address = 8'd255; bus.data = 32'hCAFE_F00D; bus.mw = 1'b1;
    PCin = 32'hFFFF_FFFC; ctr_PC_src = 1'b1;
    tick(); chk("wrap_jmp_pc", PC, 32'hFFFF_FFFC);
    bus.mw = 1'b0; ctr_PC_src = 1'b0;
    tick(); chk("wrap_pc", PC, 32'h0); chk("wrap_instr", Instr, 32'hCAFE_F00D);

    PCin = 32'h0000_0409; ctr_PC_src = 1'b1;
    tick(); chk("odd_jmp_pc", PC, 32'h0000_0409);
    ctr_PC_src = 1'b0;
    tick(); chk("odd_instr", Instr, 32'hAC08_0001); chk("odd_pc", PC, 32'h0000_040D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
